sdram_port_scheduler: RTL

- N-channel request scheduler that sits in front of the SDRAM command/control core.
- Generalises the fixed one-write/one-read auto read/write control to NUM_CH channels; each channel is statically a write or read channel.
- Adds round-robin fairness, per-channel enable, per-channel address windows with wrap, and a request/ack/done handshake.
- Output drives the control core's command, address and length inputs. GRANT steers FIFO data-path muxing.

---
 rtl/sdram_sched_pkg.sv | 45 ++++
 rtl/sdram_rr_arbiter.sv | 26 ++
 rtl/sdram_port_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared state encoding and arbitration helpers for the SDRAM port scheduler.
package sdram_sched_pkg;

    localparam int MAX_CH = 8;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_ARB    = 3'd2;
    localparam logic [2:0] ST_REQ    = 3'd3;
    localparam logic [2:0] ST_XFER   = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Walk downward so the closest channel at or after ptr wins on the last write.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] mask,
                                         input logic [2:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && mask[idx[2:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin pick over the channel eligibility mask.
module sdram_rr_arbiter
    import sdram_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CW-1:0]     ptr,
    output logic              found,
    output logic [CW-1:0]     idx
);

    logic [MAX_CH-1:0] mask_w;
    rr_pick_t          pick;

    always_comb begin
        mask_w             = '0;
        mask_w[NUM_CH-1:0] = mask;
        pick               = rr_pick(mask_w, 3'(ptr), NUM_CH);
    end

    assign found = pick.found;
    assign idx   = CW'(pick.idx);

endmodule

// File: rtl/sdram_port_scheduler.sv
// N-channel round-robin burst scheduler driving the SDRAM command core.
// state  | meaning
// INIT   | load every channel address from CH_START
// IDLE   | wait for any eligible channel
// ARB    | pick channel, latch command fields
// REQ    | REQ high until ACK
// XFER   | burst in flight, wait for DONE
// UPDATE | advance granted address, move RR pointer
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                ASIZE      = 23,
    parameter int                LSIZE      = 9,
    parameter int                LVL_W      = 16,
    parameter int                FIFO_DEPTH = 512,
    parameter logic [NUM_CH-1:0] CH_IS_WR   = 4'b0011
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_CH-1:0]         CH_EN,
    input  logic [NUM_CH-1:0]         CH_LOAD,
    input  logic [NUM_CH*ASIZE-1:0]   CH_START,
    input  logic [NUM_CH*ASIZE-1:0]   CH_MAX,
    input  logic [NUM_CH*LSIZE-1:0]   CH_LEN,
    input  logic [NUM_CH*LVL_W-1:0]   CH_LEVEL,
    output logic                      REQ,
    output logic                      REQ_WR,
    output logic [ASIZE-1:0]          REQ_ADDR,
    output logic [LSIZE-1:0]          REQ_LEN,
    output logic [clog2(NUM_CH)-1:0]  REQ_CH,
    input  logic                      ACK,
    input  logic                      DONE,
    output logic [NUM_CH-1:0]         GRANT,
    output logic                      BUSY
);

    localparam int CW  = clog2(NUM_CH);
    localparam int AW1 = ASIZE + 1;

    logic [2:0]                    state_q, state_d;
    logic [NUM_CH-1:0][ASIZE-1:0]  addr_q, addr_d;
    logic [CW-1:0]                 ptr_q, ptr_d;
    logic                          req_q, req_d;
    logic                          req_wr_q, req_wr_d;
    logic [ASIZE-1:0]              req_addr_q, req_addr_d;
    logic [LSIZE-1:0]              req_len_q, req_len_d;
    logic [CW-1:0]                 req_ch_q, req_ch_d;
    logic [NUM_CH-1:0]             grant_q, grant_d;

    logic [NUM_CH-1:0]             elig;
    logic                          pick_found;
    logic [CW-1:0]                 pick_idx;
    logic [ASIZE-1:0]              g_start, g_max;
    logic [AW1-1:0]                nxt, wrap_chk;

    // Read-side headroom is checked as level+len <= depth so an over-reported level cannot underflow.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
        logic [31:0] len_w, lvl_w;
        logic        fits;
        assign len_w   = 32'(CH_LEN[i*LSIZE +: LSIZE]);
        assign lvl_w   = 32'(CH_LEVEL[i*LVL_W +: LVL_W]);
        assign fits    = CH_IS_WR[i] ? (lvl_w >= len_w) : (lvl_w + len_w <= 32'(FIFO_DEPTH));
        assign elig[i] = CH_EN[i] && !CH_LOAD[i] && (len_w != 32'd0) && fits;
    end

    sdram_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
        .mask  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_start  = CH_START[int'(req_ch_q)*ASIZE +: ASIZE];
    assign g_max    = CH_MAX[int'(req_ch_q)*ASIZE +: ASIZE];
    assign nxt      = AW1'(addr_q[req_ch_q]) + AW1'(req_len_q);
    assign wrap_chk = nxt + AW1'(req_len_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        req_d      = req_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_ch_d   = req_ch_q;
        grant_d    = grant_q;
        case (state_q)
            ST_INIT: begin
                for (int i = 0; i < NUM_CH; i++) addr_d[i] = CH_START[i*ASIZE +: ASIZE];
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (|elig) state_d = ST_ARB;
            end
            ST_ARB: begin
                grant_d = '0;
                if (pick_found) begin
                    req_ch_d          = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                    req_wr_d          = CH_IS_WR[pick_idx];
                    req_addr_d        = addr_q[pick_idx];
                    req_len_d         = CH_LEN[int'(pick_idx)*LSIZE +: LSIZE];
                    req_d             = 1'b1;
                    state_d           = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ACK) begin
                    req_d   = 1'b0;
                    state_d = DONE ? ST_UPDATE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (DONE) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // Wrap early when the following burst would cross the window end.
                addr_d[req_ch_q] = (wrap_chk > AW1'(g_max)) ? g_start : nxt[ASIZE-1:0];
                ptr_d            = (req_ch_q == CW'(NUM_CH - 1)) ? '0 : req_ch_q + 1'b1;
                grant_d          = '0;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        if (state_q != ST_INIT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_LOAD[i]) addr_d[i] = CH_START[i*ASIZE +: ASIZE];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_INIT;
            addr_q     <= '0;
            ptr_q      <= '0;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            req_ch_q   <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            req_q      <= req_d;
            req_wr_q   <= req_wr_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            req_ch_q   <= req_ch_d;
            grant_q    <= grant_d;
        end
    end

    assign REQ      = req_q;
    assign REQ_WR   = req_wr_q;
    assign REQ_ADDR = req_addr_q;
    assign REQ_LEN  = req_len_q;
    assign REQ_CH   = req_ch_q;
    assign GRANT    = grant_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule
